// File: rtl/mult_acc_unit_if.sv
// Handshake bundle between a product source, the accumulator and its result consumer.
interface mult_acc_unit_if #(
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned ACC_W = 64;

  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] prod;
  logic             in_clear;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  // Producer / consumer side (testbench or surrounding datapath)
  modport master (
    output in_valid, prod, in_clear, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  // Accumulator side
  modport slave (
    input  in_valid, prod, in_clear, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/mult_acc_unit.sv
// Accumulates 64-bit multiplier products into groups and holds each group
// result (sum mod 2^64, saturating beat count, sticky carry flag) until taken.
module mult_acc_unit #(
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  mult_acc_unit_if.slave bus
);
  localparam int unsigned ACC_W = 64;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic             fresh, fresh_next;
  logic [ACC_W-1:0] acc, acc_next;
  logic [CNT_W-1:0] count, count_next;
  logic             ovf, ovf_next;
  logic             in_ready_q, out_valid_q;

  logic             accept_c;
  logic [ACC_W:0]   sum_c;

  assign accept_c = bus.in_valid && in_ready_q;
  assign sum_c    = {1'b0, acc} + {1'b0, bus.prod};

  // Next-state and datapath update; a beat after a handoff or reset always loads
  always_comb begin
    state_next = state;
    fresh_next = fresh;
    acc_next   = acc;
    count_next = count;
    ovf_next   = ovf;
    case (state)
      ACCUM: begin
        if (accept_c) begin
          if (bus.in_clear || fresh) begin
            acc_next   = bus.prod;
            count_next = CNT_W'(1);
            ovf_next   = 1'b0;
          end else begin
            acc_next = sum_c[ACC_W-1:0];
            ovf_next = ovf | sum_c[ACC_W];
            if (count != CNT_MAX) begin
              count_next = count + CNT_W'(1);
            end
          end
          fresh_next = 1'b0;
          if (bus.in_last) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_next = ACCUM;
          fresh_next = 1'b1;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // State, datapath and handshake registers; handshake flags track the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACCUM;
      fresh       <= 1'b1;
      acc         <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      fresh       <= fresh_next;
      acc         <= acc_next;
      count       <= count_next;
      ovf         <= ovf_next;
      in_ready_q  <= (state_next == ACCUM);
      out_valid_q <= (state_next == HOLD);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = acc;
  assign bus.out_count = count;
  assign bus.out_ovf   = ovf;
endmodule

// File: doc/mult_acc_unit.md
MULT_ACC_UNIT -- requirements
Module: mult_acc_unit

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the beat counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1, meaning a 64-bit product beat is presented.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts a beat this cycle.
REQ-006 The block SHALL have port prod, input, 64, the unsigned product from the 32x32 Wallace multiplier output.
REQ-007 The block SHALL have port in_clear, input, 1, meaning this beat starts a new group (load, not add).
REQ-008 The block SHALL have port in_last, input, 1, meaning this beat ends the group.
REQ-009 The block SHALL have port out_valid, output, 1, meaning a group result is held.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 The block SHALL have port out_acc, output, 64, the group sum modulo 2^64.
REQ-012 The block SHALL have port out_count, output, CNT_W, the number of beats in the group, saturating.
REQ-013 The block SHALL have port out_ovf, output, 1, a sticky flag set if any add in the group produced a carry-out of bit 63.

Function
REQ-014 The block SHALL implement a two-state FSM: ACCUM and HOLD.
REQ-015 in_ready SHALL be 1 exactly when the state is ACCUM; out_valid SHALL be 1 exactly when the state is HOLD; both are driven from registered state only.
REQ-016 A beat SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; a beat presented while in_ready=0 SHALL have no effect.
REQ-017 The block SHALL keep an internal flag fresh; fresh is set by reset and on every result handoff.
REQ-018 Load beat: an accepted beat with in_clear=1 or fresh=1 SHALL set acc=prod, count=1, ovf=0 and clear fresh.
REQ-019 Add beat: any other accepted beat SHALL set {carry,acc}=acc+prod (65-bit); acc keeps the low 64 bits; ovf |= carry; count increments and holds at 2^CNT_W-1.
REQ-020 An accepted beat with in_last=1 SHALL move the FSM to HOLD on the same edge; out_valid SHALL rise the cycle after acceptance (latency 1).
REQ-021 in_clear=1 with in_last=1 on one beat SHALL form a single-beat group: out_acc=prod, out_count=1, out_ovf=0.
REQ-022 In HOLD, out_acc, out_count and out_ovf SHALL remain stable until the handoff.
REQ-023 Handoff: in HOLD with out_ready=1, the FSM SHALL return to ACCUM on that edge and set fresh; out_valid drops the next cycle.
REQ-024 The block SHALL have no bypass: in_ready stays 0 during the handoff cycle, so the earliest next acceptance is the cycle after the handoff.
REQ-025 in_clear=1 mid-group SHALL discard the partial sum and restart per REQ-018.
REQ-026 out_acc, out_count and out_ovf SHALL be the acc, count and ovf registers directly; in ACCUM they show the partial values, valid only while out_valid=1.

Reset
REQ-027 Assertion of rst SHALL, asynchronously and at any time including mid-group or in HOLD, force: state=ACCUM, fresh=1, acc=0, count=0, ovf=0.
REQ-028 The reset of REQ-027 SHALL give in_ready=1, out_valid=0, out_acc=0, out_count=0 and out_ovf=0.
REQ-029 A partial group interrupted by rst SHALL be discarded; the first beat after release is a load beat.

Verification
REQ-030 Scenario: beats prod=10, 20, 30 (first in_clear=1, last in_last=1) with out_ready=1 -> out_valid pulses 1 cycle after the third acceptance with out_acc=60, out_count=3, out_ovf=0.
REQ-031 Scenario: beats 0xFFFF_FFFF_FFFF_FFFF then 2 (in_last on the second) -> out_acc=1, out_count=2, out_ovf=1.
REQ-032 Scenario: result held with out_ready=0 for 5 cycles -> out_valid=1, outputs stable, in_ready=0 and beats ignored; then out_ready=1 -> in_ready=1 the next cycle.
REQ-033 Scenario: CNT_W=8 with 300 beats of prod=1 -> out_count=255, out_acc=300.
REQ-034 Scenario: rst asserted after 2 of 4 beats, then a new group of 7 and 8 -> out_acc=15, out_count=2, with no residue from the old group.
REQ-035 Scenario: in_clear=1 on the third beat of a 10, 20, 5, 6 group -> out_acc=11, out_count=2.
